// File: rtl/misr_sig_gen_pkg.sv
// Shared types for the signature generator: FSM state encoding and a table
// of default feedback polynomials indexed by signature width.
package misr_sig_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit k set means sig[W-1] is fed back into bit k; bit 0 is always fed.
    function automatic logic [63:0] default_poly(input int w);
        logic [63:0] p;
        case (w)
            2:       p = 64'h3;
            3:       p = 64'h3;
            4:       p = 64'h3;
            5:       p = 64'h5;
            6:       p = 64'h3;
            7:       p = 64'h3;
            8:       p = 64'h1D;
            16:      p = 64'h100B;
            32:      p = 64'h0040_0007;
            default: p = 64'h3;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/misr_sig_gen_lfsr_step.sv
// One Galois LFSR step: shifts sig up by one, folds the top bit back through
// POLY and XORs up to N_IN parallel data bits into the low end.
module lfsr_step
    import misr_sig_gen_pkg::*;
#(
    parameter int             W    = 8,
    parameter int             N_IN = 1,
    parameter logic [W-1:0]   POLY = W'(default_poly(W))
) (
    input  logic [W-1:0]    sig,
    input  logic [N_IN-1:0] d,
    output logic [W-1:0]    nxt
);

    logic [W-1:0] d_w;
    logic         f;

    always_comb begin
        d_w            = '0;
        d_w[N_IN-1:0]  = d;
        f              = sig[W-1];
        nxt            = '0;
        nxt[0]         = f ^ d_w[0];
        for (int k = 1; k < W; k++) begin
            nxt[k] = sig[k-1] ^ (POLY[k] & f) ^ d_w[k];
        end
    end

endmodule

// File: rtl/misr_sig_gen.sv
// Signature register for the self-test path: compresses din (or free-runs)
// for len steps, then compares the result against expect_sig.
module misr_sig_gen
    import misr_sig_gen_pkg::*;
#(
    parameter int           W     = 8,
    parameter logic [W-1:0] POLY  = W'(default_poly(W)),
    parameter int           N_IN  = 1,
    parameter logic [W-1:0] SEED  = {W{1'b1}},
    parameter int           CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             seed_ld,
    input  logic [W-1:0]     seed,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  din,
    input  logic [W-1:0]     expect_sig,
    output logic [W-1:0]     sig,
    output logic             busy,
    output logic             done,
    output logic             match,
    output logic [1:0]       state_dbg
);

    // Handshake: a step is taken on every rising edge where in_valid=1 while
    // busy=1; there is no back-pressure, the register always accepts a step.

    state_e           state_q, state_d;
    logic [W-1:0]     sig_q, sig_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             match_q, match_d;
    logic [N_IN-1:0]  din_gated;
    logic [W-1:0]     sig_step;

    // Generate mode runs the same recurrence with the data term forced to zero.
    assign din_gated = mode_q ? '0 : din;

    lfsr_step #(
        .W    (W),
        .N_IN (N_IN),
        .POLY (POLY)
    ) u_step (
        .sig (sig_q),
        .d   (din_gated),
        .nxt (sig_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sig_q   <= SEED;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        match_d = match_q;
        case (state_q)
            ST_IDLE: begin
                if (seed_ld) begin
                    sig_d = seed;
                end
                if (start) begin
                    mode_d  = mode;
                    cnt_d   = len;
                    match_d = 1'b0;
                    state_d = (len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    sig_d = sig_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                match_d = (sig_q == expect_sig);
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sig       = sig_q;
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign match     = match_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_misr_sig_gen.sv
// Directed bench for misr_sig_gen at W=4, POLY=x^4+x+1: a serial (N_IN=1)
// and a parallel (N_IN=4) instance share the control inputs.
module tb_misr_sig_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mode = 1'b0;
    logic        seed_ld = 1'b0;
    logic [3:0]  seed = '0;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        in_valid = 1'b0;
    logic        din1 = 1'b0;
    logic [3:0]  din4 = '0;
    logic [3:0]  expect_sig = '0;

    logic [3:0]  sig1, sig4;
    logic        busy1, busy4, done1, done4, match1, match4;
    logic [1:0]  st1, st4;

    int checks = 0;
    int errors = 0;

    misr_sig_gen #(.W(4), .POLY(4'h3), .N_IN(1), .SEED(4'hF), .CNT_W(16)) u1 (
        .clk(clk), .rst(rst), .mode(mode), .seed_ld(seed_ld), .seed(seed),
        .start(start), .len(len), .in_valid(in_valid), .din(din1),
        .expect_sig(expect_sig), .sig(sig1), .busy(busy1), .done(done1),
        .match(match1), .state_dbg(st1)
    );

    misr_sig_gen #(.W(4), .POLY(4'h3), .N_IN(4), .SEED(4'hF), .CNT_W(16)) u4 (
        .clk(clk), .rst(rst), .mode(mode), .seed_ld(seed_ld), .seed(seed),
        .start(start), .len(len), .in_valid(in_valid), .din(din4),
        .expect_sig(expect_sig), .sig(sig4), .busy(busy4), .done(done4),
        .match(match4), .state_dbg(st4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [3:0]  seed;
        logic [15:0] len;
        logic [15:0] din_bits;
        logic        gaps;
        logic [3:0]  expect_v;
        logic [3:0]  exp_sig;
        logic        exp_match;
    } vec_t;

    vec_t vecs[6];
    logic [3:0] gen_seq[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Seed, start, step through the run (optionally with idle gaps carrying
    // ignored control pulses), then check done, final signature and match.
    task automatic run_vec(input int id, input vec_t v);
        int steps;
        int cyc;
        seed_ld = 1'b1;
        seed    = v.seed;
        tick();
        seed_ld = 1'b0;
        chk($sformatf("v%0d_seed_ld", id), 16'(sig1), 16'(v.seed));
        mode  = v.mode;
        len   = v.len;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk($sformatf("v%0d_match_clr", id), 16'(match1), 16'h0);
        chk($sformatf("v%0d_busy_start", id), 16'(busy1), 16'(v.len != 16'd0));
        steps = 0;
        cyc   = 0;
        while (busy1 && cyc < 64) begin
            if (v.gaps && cyc[0]) begin
                in_valid = 1'b0;
                din1     = 1'b1;
                start    = 1'b1;
                seed_ld  = 1'b1;
                seed     = 4'hA;
                len      = 16'd3;
            end else begin
                in_valid = 1'b1;
                din1     = v.din_bits[steps[3:0]];
                steps++;
            end
            tick();
            start   = 1'b0;
            seed_ld = 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        din1     = 1'b0;
        chk($sformatf("v%0d_step_count", id), 16'(steps), v.len);
        chk($sformatf("v%0d_done_pulse", id), 16'({done1, busy1}), 16'b10);
        chk($sformatf("v%0d_sig_final", id), 16'(sig1), 16'(v.exp_sig));
        expect_sig = v.expect_v;
        tick();
        chk($sformatf("v%0d_done_single", id), 16'(done1), 16'h0);
        chk($sformatf("v%0d_match", id), 16'(match1), 16'(v.exp_match));
        expect_sig = ~v.expect_v;
        tick();
        chk($sformatf("v%0d_match_held", id), 16'(match1), 16'(v.exp_match));
    endtask

    initial begin
        vecs[0] = '{1'b0, 4'h0, 16'd5, 16'h0001, 1'b0, 4'h3, 4'h3, 1'b1};
        vecs[1] = '{1'b0, 4'h0, 16'd5, 16'h0001, 1'b0, 4'h7, 4'h3, 1'b0};
        vecs[2] = '{1'b0, 4'h0, 16'd5, 16'h0001, 1'b1, 4'h3, 4'h3, 1'b1};
        vecs[3] = '{1'b0, 4'h6, 16'd0, 16'h0000, 1'b0, 4'h6, 4'h6, 1'b1};
        vecs[4] = '{1'b1, 4'h1, 16'd4, 16'hFFFF, 1'b0, 4'h3, 4'h3, 1'b1};
        vecs[5] = '{1'b0, 4'hF, 16'd3, 16'h0005, 1'b0, 4'h4, 4'h4, 1'b1};
        gen_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
                    4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9, 4'h1};

        // Reset state
        #1 rst = 1'b1;
        tick();
        tick();
        chk("rst_sig", 16'(sig1), 16'hF);
        chk("rst_flags", 16'({busy1, done1, match1}), 16'h0);
        chk("rst_state", 16'(st1), 16'h0);
        rst = 1'b0;
        tick();

        // Generator: full period of x^4+x+1 from 0001
        seed_ld = 1'b1;
        seed    = 4'h1;
        tick();
        seed_ld = 1'b0;
        mode    = 1'b1;
        len     = 16'd15;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk($sformatf("gen_sig_%0d", i), 16'(sig1), 16'(gen_seq[i+1]));
            chk($sformatf("gen_busy_done_%0d", i), 16'({busy1, done1}),
                (i < 14) ? 16'b10 : 16'b01);
        end
        in_valid   = 1'b0;
        expect_sig = 4'h1;
        tick();
        chk("gen_match", 16'({done1, match1}), 16'b01);

        // Table-driven runs
        for (int i = 0; i < 6; i++) begin
            run_vec(i, vecs[i]);
        end

        // Parallel compression on the 4-input instance
        seed_ld = 1'b1;
        seed    = 4'h0;
        tick();
        seed_ld = 1'b0;
        mode    = 1'b0;
        len     = 16'd2;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        din4     = 4'b1010;
        tick();
        chk("misr_step1", 16'(sig4), 16'b1010);
        din4 = 4'b0101;
        tick();
        in_valid = 1'b0;
        din4     = 4'b0000;
        chk("misr_step2", 16'(sig4), 16'b0010);
        chk("misr_done", 16'(done4), 16'h1);
        expect_sig = 4'b0010;
        tick();
        chk("misr_match", 16'(match4), 16'h1);

        // Reset in the middle of a serial run
        seed_ld = 1'b1;
        seed    = 4'h0;
        tick();
        seed_ld = 1'b0;
        len     = 16'd5;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        din1     = 1'b1;
        tick();
        din1 = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("pre_reset_sig", 16'(sig1), 16'h2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sig", 16'(sig1), 16'hF);
        chk("mid_rst_flags", 16'({busy1, done1, match1}), 16'h0);
        chk("mid_rst_state", 16'(st1), 16'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_rst_idle_%0d", i), 16'({busy1, done1}), 16'h0);
        end
        run_vec(6, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
